// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter_pkg
// Brief    : Shared widths, zero-register constant and write-request type.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_write_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rg;
        logic [DATA_W-1:0]     data;
    } wr_req_t;

    function automatic wr_req_t idle_req();
        wr_req_t r;
        r.valid = 1'b0;
        r.rg    = ZERO_REG;
        r.data  = '0;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter_if
// Brief    : Source ports, register-file write port and hazard query bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_write_arbiter_if;
    import regfile_write_arbiter_pkg::*;

    logic                  a_valid;
    logic [REG_ADDR_W-1:0] a_rg;
    logic [DATA_W-1:0]     a_data;

    logic                  b_valid;
    logic                  b_ready;
    logic [REG_ADDR_W-1:0] b_rg;
    logic [DATA_W-1:0]     b_data;

    logic [REG_ADDR_W-1:0] write_rg;
    logic                  reg_write;
    logic [DATA_W-1:0]     write_data;

    logic [REG_ADDR_W-1:0] q_rg1;
    logic [REG_ADDR_W-1:0] q_rg2;
    logic                  q_hit1;
    logic                  q_hit2;
    logic [DATA_W-1:0]     q_data1;
    logic [DATA_W-1:0]     q_data2;

    logic                  stall_req;

    // The arbiter side: consumes both sources, owns the write port.
    modport master (
        input  a_valid, a_rg, a_data,
        input  b_valid, b_rg, b_data,
        output b_ready,
        output write_rg, reg_write, write_data,
        input  q_rg1, q_rg2,
        output q_hit1, q_hit2, q_data1, q_data2,
        output stall_req
    );

    modport slave (
        output a_valid, a_rg, a_data,
        output b_valid, b_rg, b_data,
        input  b_ready,
        input  write_rg, reg_write, write_data,
        output q_rg1, q_rg2,
        input  q_hit1, q_hit2, q_data1, q_data2,
        input  stall_req
    );

endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter_wb_fifo
// Brief    : Long-latency result FIFO with per-entry kill and youngest-match
//            hazard lookup.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter_wb_fifo
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] push_rg,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop,
    input  logic                  kill,
    input  logic [REG_ADDR_W-1:0] kill_rg,
    input  logic [REG_ADDR_W-1:0] q_rg1,
    input  logic [REG_ADDR_W-1:0] q_rg2,
    output logic                  full,
    output logic                  empty,
    output wr_req_t               head,
    output logic                  q_hit1,
    output logic                  q_hit2,
    output logic [DATA_W-1:0]     q_data1,
    output logic [DATA_W-1:0]     q_data2
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]          r_wr_ptr;
    logic [PTR_W:0]          r_rd_ptr;
    logic [DEPTH-1:0]        r_valid;
    logic [REG_ADDR_W-1:0]   r_rg   [DEPTH];
    logic [DATA_W-1:0]       r_data [DEPTH];

    logic [PTR_W:0]          w_count;
    logic [PTR_W-1:0]        w_wr_idx;
    logic [PTR_W-1:0]        w_rd_idx;

    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_wr_idx = r_wr_ptr[PTR_W-1:0];
    assign w_rd_idx = r_rd_ptr[PTR_W-1:0];
    assign full     = (w_count == (PTR_W+1)'(DEPTH));
    assign empty    = (r_wr_ptr == r_rd_ptr);

    assign head.valid = r_valid[w_rd_idx];
    assign head.rg    = r_rg[w_rd_idx];
    assign head.data  = r_data[w_rd_idx];

    // The push assignment comes last so an entry written this edge is never
    // caught by a kill issued in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_valid  <= '0;
        end else begin
            if (kill) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_rg[i] == kill_rg) begin
                        r_valid[i] <= 1'b0;
                    end
                end
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (push) begin
                r_valid[w_wr_idx] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            r_rg[w_wr_idx]   <= push_rg;
            r_data[w_wr_idx] <= push_data;
        end
    end

    // Scan oldest to youngest so the last live match found wins.
    always_comb begin
        logic [PTR_W-1:0] v_idx;
        v_idx   = '0;
        q_hit1  = 1'b0;
        q_hit2  = 1'b0;
        q_data1 = '0;
        q_data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_idx = w_rd_idx + PTR_W'(i);
            if (((PTR_W+1)'(i) < w_count) && r_valid[v_idx]) begin
                if ((q_rg1 != ZERO_REG) && (r_rg[v_idx] == q_rg1)) begin
                    q_hit1  = 1'b1;
                    q_data1 = r_data[v_idx];
                end
                if ((q_rg2 != ZERO_REG) && (r_rg[v_idx] == q_rg2)) begin
                    q_hit2  = 1'b1;
                    q_data2 = r_data[v_idx];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Brief    : Single write-port owner for the register file, merging pipeline
//            writeback with buffered long-latency results.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
)
(
    input  logic                   clk,
    input  logic                   rst,
    regfile_write_arbiter_if.master bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic             w_full;
    logic             w_empty;
    wr_req_t          w_head;
    logic             w_a_issue;
    logic             w_push;
    logic             w_pop;
    wr_req_t          w_next;
    logic [CNT_W-1:0] w_cnt_next;

    wr_req_t          r_out;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stall;

    assign w_a_issue   = bus.a_valid && (bus.a_rg != ZERO_REG);
    assign bus.b_ready = !w_full && !rst;
    assign w_push      = bus.b_valid && bus.b_ready && (bus.b_rg != ZERO_REG);

    // A stalled head would pop ahead of A, but an A that arrives anyway wins;
    // both cases reduce to "pop whenever A is not issuing".
    assign w_pop = !w_a_issue && !w_empty;

    regfile_write_arbiter_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_wb_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_rg   (bus.b_rg),
        .push_data (bus.b_data),
        .pop       (w_pop),
        .kill      (w_a_issue),
        .kill_rg   (bus.a_rg),
        .q_rg1     (bus.q_rg1),
        .q_rg2     (bus.q_rg2),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head),
        .q_hit1    (bus.q_hit1),
        .q_hit2    (bus.q_hit2),
        .q_data1   (bus.q_data1),
        .q_data2   (bus.q_data2)
    );

    // A killed head still takes its slot but leaves the write port idle.
    always_comb begin
        w_next = idle_req();
        if (w_a_issue) begin
            w_next.valid = 1'b1;
            w_next.rg    = bus.a_rg;
            w_next.data  = bus.a_data;
        end else if (w_pop && w_head.valid) begin
            w_next = w_head;
        end
    end

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_empty || w_pop) begin
            w_cnt_next = '0;
        end else if (r_cnt != CNT_MAX) begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out   <= idle_req();
            r_cnt   <= '0;
            r_stall <= 1'b0;
        end else begin
            r_out   <= w_next;
            r_cnt   <= w_cnt_next;
            r_stall <= (w_cnt_next == CNT_MAX);
        end
    end

    assign bus.reg_write  = r_out.valid;
    assign bus.write_rg   = r_out.rg;
    assign bus.write_data = r_out.data;
    assign bus.stall_req  = r_stall;

endmodule
`default_nettype wire
